frame_transmitter: RTL and testbench

- Avalon-MM configured Ethernet-style frame generator.
- Drives a 16-bit AXI-Stream egress port and is the transmit-side counterpart of the frame receptor.
- Word layout: PREAMBLE_WORDS preamble words, 3 dst MAC words, 3 src MAC words, 1 ethertype word, then N payload words. tlast is asserted on the final payload word.
- Payload is an incrementing 16-bit pattern from a programmable seed. A 32-bit payload checksum is computed with the same rule the receptor uses, so loopback checks compare directly.

---
 rtl/frame_transmitter_pkg.sv | 15 +
 rtl/frame_transmitter_regs.sv | 92 +++++++++
 rtl/frame_transmitter.sv | 128 ++++++++++++
 tb/tb_frame_transmitter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/frame_transmitter_pkg.sv
// frame_transmitter_pkg: shared FSM states, register addresses and frame constants
package frame_transmitter_pkg;
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_DST, S_SRC, S_TYPE, S_PAY, S_GAP} tx_state_t;
  localparam int STUBBING_PASSTHROUGH = 1;
  localparam int NUM_CFG = 19;
  localparam logic [7:0] ADDR_CTRL = 8'd19;
  localparam logic [7:0] ADDR_SENT = 8'd20;
  localparam logic [7:0] ADDR_CSUM = 8'd21;
  localparam logic [15:0] PREAMBLE_WORD = 16'h5555;
  localparam logic [15:0] SFD_WORD = 16'h55D5;
  localparam int HDR_MAC_WORDS = 3;
  function automatic logic [15:0] mac_word(input logic [47:0] mac, input logic [1:0] k);
    return k == 2'd0 ? mac[15:0] : k == 2'd1 ? mac[31:16] : mac[47:32];
  endfunction
endpackage

// File: rtl/frame_transmitter_regs.sv
// frame_tx_regs: Avalon register file, start pulse, per-frame snapshot and readback (FRAME_TX_STALL_COUNT_EN adds the stall counter)
module frame_tx_regs
  import frame_transmitter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  i_writedata,
  input  logic        i_write,
  input  logic        i_chipselect,
  input  logic [7:0]  i_address,
  input  logic        i_read,
  output logic [7:0]  o_readdata,
  input  logic        i_busy,
  input  logic [7:0]  i_frames_sent,
  input  logic [31:0] i_checksum,
  input  logic        i_snap,
`ifdef FRAME_TX_STALL_COUNT_EN
  input  logic        i_stall,
`endif
  output logic        o_start,
  output logic [7:0]  o_count,
  output logic [47:0] o_dst,
  output logic [47:0] o_src,
  output logic [15:0] o_type,
  output logic [15:0] o_seed,
  output logic [7:0]  o_len,
  output logic [7:0]  o_gap
);
  logic [7:0] r_cfg [NUM_CFG];
  logic [47:0] r_dst, r_src;
  logic [15:0] r_type, r_seed;
  logic [7:0] r_len, r_gap, w_rd;
  logic w_wr;
  assign w_wr = i_chipselect && i_write;
  assign o_start = w_wr && i_address == ADDR_CTRL && i_writedata[0];
  assign o_count = r_cfg[18];
  assign o_dst = r_dst;
  assign o_src = r_src;
  assign o_type = r_type;
  assign o_seed = r_seed;
  assign o_len = r_len;
  assign o_gap = r_gap;
  // Live configuration registers at addresses 0-18
  always_ff @(posedge clk)
    if (reset) for (int i = 0; i < NUM_CFG; i++) r_cfg[i] <= '0;
    else if (w_wr && i_address < ADDR_CTRL) r_cfg[i_address[4:0]] <= i_writedata;
  // Snapshot taken as each frame begins so mid-frame writes only affect later frames
  always_ff @(posedge clk)
    if (reset) begin
      r_dst <= '0;
      r_src <= '0;
      r_type <= '0;
      r_seed <= '0;
      r_len <= '0;
      r_gap <= '0;
    end else if (i_snap) begin
      r_dst <= {r_cfg[5], r_cfg[4], r_cfg[3], r_cfg[2], r_cfg[1], r_cfg[0]};
      r_src <= {r_cfg[11], r_cfg[10], r_cfg[9], r_cfg[8], r_cfg[7], r_cfg[6]};
      r_type <= {r_cfg[13], r_cfg[12]};
      r_len <= r_cfg[14];
      r_gap <= r_cfg[15];
      r_seed <= {r_cfg[17], r_cfg[16]};
    end
`ifdef FRAME_TX_STALL_COUNT_EN
  logic [15:0] r_stall;
  // Saturating count of stalled stream cycles; any write to its low byte clears it
  always_ff @(posedge clk)
    if (reset || (w_wr && i_address == 8'd25)) r_stall <= '0;
    else if (i_stall && r_stall != 16'hFFFF) r_stall <= r_stall + 16'd1;
`endif
  // Readback mux; unmapped addresses read as zero
  always_comb begin
    w_rd = i_address < ADDR_CTRL ? r_cfg[i_address[4:0]] : 8'd0;
    case (i_address)
      ADDR_CTRL:         w_rd = {7'd0, i_busy};
      ADDR_SENT:         w_rd = i_frames_sent;
      ADDR_CSUM:         w_rd = i_checksum[7:0];
      ADDR_CSUM + 8'd1:  w_rd = i_checksum[15:8];
      ADDR_CSUM + 8'd2:  w_rd = i_checksum[23:16];
      ADDR_CSUM + 8'd3:  w_rd = i_checksum[31:24];
`ifdef FRAME_TX_STALL_COUNT_EN
      8'd25:             w_rd = r_stall[7:0];
      8'd26:             w_rd = r_stall[15:8];
`endif
      default: ;
    endcase
  end
  // Read data registered; zero on cycles without a read
  always_ff @(posedge clk)
    if (reset) o_readdata <= '0;
    else o_readdata <= (i_chipselect && i_read) ? w_rd : 8'd0;
endmodule

// File: rtl/frame_transmitter.sv
// frame_transmitter: Avalon-configured frame generator on a 16-bit AXI-Stream egress (FRAME_TX_STALL_COUNT_EN adds a stall counter)
module frame_transmitter
  import frame_transmitter_pkg::*;
#(
  parameter int STUBBING = STUBBING_PASSTHROUGH,
  parameter int PREAMBLE_WORDS = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  writedata,
  input  logic        write,
  input  logic        chipselect,
  input  logic [7:0]  address,
  input  logic        read,
  output logic [7:0]  readdata,
  output logic [15:0] egress_port_tdata,
  output logic        egress_port_tvalid,
  input  logic        egress_port_tready,
  output logic        egress_port_tlast
);
  tx_state_t r_state, w_state_n;
  logic [7:0] r_idx, w_idx_n, r_gap_cnt, w_gap_n, r_left, r_sent;
  logic [31:0] r_sum, r_csum;
  logic [47:0] w_dst, w_src;
  logic [15:0] w_type, w_seed, w_pay;
  logic [7:0] w_len, w_gap, w_count, w_last_idx;
  logic w_start, w_start_ok, w_snap, w_fire, w_eof;
  frame_tx_regs u_regs (
    .clk(clk),
    .reset(reset),
    .i_writedata(writedata),
    .i_write(write),
    .i_chipselect(chipselect),
    .i_address(address),
    .i_read(read),
    .o_readdata(readdata),
    .i_busy(r_state != S_IDLE),
    .i_frames_sent(r_sent),
    .i_checksum(r_csum),
    .i_snap(w_snap),
`ifdef FRAME_TX_STALL_COUNT_EN
    .i_stall(egress_port_tvalid && !egress_port_tready),
`endif
    .o_start(w_start),
    .o_count(w_count),
    .o_dst(w_dst),
    .o_src(w_src),
    .o_type(w_type),
    .o_seed(w_seed),
    .o_len(w_len),
    .o_gap(w_gap)
  );
  assign w_pay = w_seed + {8'd0, r_idx};
  assign w_last_idx = w_len == 8'd0 ? 8'd0 : w_len - 8'd1;
  assign egress_port_tvalid = (r_state inside {S_PRE, S_DST, S_SRC, S_TYPE, S_PAY}) && (STUBBING != STUBBING_PASSTHROUGH);
  assign egress_port_tlast = r_state == S_PAY && r_idx == w_last_idx;
  assign egress_port_tdata = r_state == S_PRE ? (r_idx == 8'(PREAMBLE_WORDS - 1) ? SFD_WORD : PREAMBLE_WORD)
                           : r_state == S_DST ? mac_word(w_dst, r_idx[1:0])
                           : r_state == S_SRC ? mac_word(w_src, r_idx[1:0])
                           : r_state == S_TYPE ? w_type
                           : r_state == S_PAY ? w_pay : 16'd0;
  assign w_fire = egress_port_tvalid && egress_port_tready;
  assign w_eof = w_fire && egress_port_tlast;
  assign w_start_ok = w_start && r_state == S_IDLE && w_count != 8'd0 && (STUBBING != STUBBING_PASSTHROUGH);
  assign w_snap = w_state_n == S_PRE && r_state != S_PRE;
  // Next state: words and states advance only on an accepted beat
  always_comb begin
    w_state_n = r_state;
    w_idx_n = w_fire ? r_idx + 8'd1 : r_idx;
    w_gap_n = r_gap_cnt;
    case (r_state)
      S_IDLE: if (w_start_ok) w_state_n = S_PRE;
      S_PRE: if (w_fire && r_idx == 8'(PREAMBLE_WORDS - 1)) begin
        w_state_n = S_DST;
        w_idx_n = '0;
      end
      S_DST: if (w_fire && r_idx == 8'(HDR_MAC_WORDS - 1)) begin
        w_state_n = S_SRC;
        w_idx_n = '0;
      end
      S_SRC: if (w_fire && r_idx == 8'(HDR_MAC_WORDS - 1)) begin
        w_state_n = S_TYPE;
        w_idx_n = '0;
      end
      S_TYPE: if (w_fire) begin
        w_state_n = S_PAY;
        w_idx_n = '0;
      end
      S_PAY: if (w_eof) begin
        w_idx_n = '0;
        w_gap_n = w_gap;
        if (r_left == 8'd1) w_state_n = S_IDLE;
        else if (w_gap != 8'd0) w_state_n = S_GAP;
        else w_state_n = S_PRE;
      end
      S_GAP: begin
        w_gap_n = r_gap_cnt - 8'd1;
        if (r_gap_cnt == 8'd1) w_state_n = S_PRE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end
  // State, word counter and gap countdown
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= S_IDLE;
      r_idx <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_state <= w_state_n;
      r_idx <= w_idx_n;
      r_gap_cnt <= w_gap_n;
    end
  // Burst bookkeeping and payload checksum, published on the accepted last word
  always_ff @(posedge clk)
    if (reset) begin
      r_left <= '0;
      r_sent <= '0;
      r_sum <= '0;
      r_csum <= '0;
    end else begin
      if (w_start_ok) r_left <= w_count;
      else if (w_eof) r_left <= r_left - 8'd1;
      if (w_eof) r_sent <= r_sent + 8'd1;
      if (w_fire && r_state == S_PAY) r_sum <= w_eof ? 32'd0 : r_sum + {16'd0, w_pay};
      if (w_eof) r_csum <= r_sum + {16'd0, w_pay};
    end
endmodule

// File: tb/tb_frame_transmitter.sv
// tb_frame_transmitter: scoreboard bench for frame_transmitter
module tb_frame_transmitter;
  logic clk = 0, reset = 1;
  logic [7:0] writedata = 0, address = 0, readdata;
  logic write = 0, chipselect = 0, read = 0;
  logic [15:0] tdata;
  logic tvalid, tlast, tready = 1;
  int checks = 0, passes = 0, stalls = 0, tlasts = 0, gap_cnt = 0;
  logic [16:0] exp_q[$];
  int gap_q[$];
  logic counting = 0, rnd = 0, prev_stall = 0, prev_last = 0;
  logic [15:0] prev_data = 0;
  localparam logic [47:0] DST = 48'h060504030201, SRC = 48'h0F0E0D0C0B0A, DST2 = 48'h0605040302AA;
  logic [15:0] golden [14] = '{16'h5555, 16'h5555, 16'h55D5, 16'h0201, 16'h0403, 16'h0605, 16'h0B0A,
                               16'h0D0C, 16'h0F0E, 16'h0800, 16'h0010, 16'h0011, 16'h0012, 16'h0013};
  always #5 clk = ~clk;
  frame_transmitter #(.STUBBING(0), .PREAMBLE_WORDS(3)) dut (
    .clk(clk), .reset(reset), .writedata(writedata), .write(write), .chipselect(chipselect),
    .address(address), .read(read), .readdata(readdata), .egress_port_tdata(tdata),
    .egress_port_tvalid(tvalid), .egress_port_tready(tready), .egress_port_tlast(tlast)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    chipselect = 1; write = 1; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 0; write = 0;
  endtask
  task automatic rd_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
    @(posedge clk); #1;
    chipselect = 1; read = 1; address = a;
    @(posedge clk); #1;
    chipselect = 0; read = 0;
    chk(name, {24'd0, readdata}, {24'd0, exp});
  endtask
  task automatic setup(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] typ,
                       input logic [15:0] seed, input logic [7:0] len, input logic [7:0] gap, input logic [7:0] cnt);
    for (int i = 0; i < 6; i++) begin
      wr(8'(i), dst[8*i +: 8]);
      wr(8'(6 + i), src[8*i +: 8]);
    end
    wr(12, typ[7:0]); wr(13, typ[15:8]); wr(14, len); wr(15, gap);
    wr(16, seed[7:0]); wr(17, seed[15:8]); wr(18, cnt);
  endtask
  task automatic push_frame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] typ,
                            input logic [15:0] seed, input int len);
    int n = len == 0 ? 1 : len;
    exp_q.push_back({1'b0, 16'h5555});
    exp_q.push_back({1'b0, 16'h5555});
    exp_q.push_back({1'b0, 16'h55D5});
    for (int k = 0; k < 3; k++) exp_q.push_back({1'b0, dst[16*k +: 16]});
    for (int k = 0; k < 3; k++) exp_q.push_back({1'b0, src[16*k +: 16]});
    exp_q.push_back({1'b0, typ});
    for (int i = 0; i < n; i++) exp_q.push_back({i == n - 1, 16'(seed + 16'(i))});
  endtask
  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || tvalid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, n < 2000}, 32'd1);
  endtask
  always @(posedge clk) begin
    #1;
    tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  always @(negedge clk) begin
    if (prev_stall) chk("stall_hold", {14'd0, tvalid, tlast, tdata}, {14'd0, 1'b1, prev_last, prev_data});
    if (tvalid && !tready) stalls++;
    prev_stall = tvalid && !tready;
    prev_data = tdata;
    prev_last = tlast;
    if (counting) begin
      if (tvalid) begin
        gap_q.push_back(gap_cnt);
        counting = 0;
      end else gap_cnt++;
    end
    if (tvalid && tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL extra_word: got 0x%0h expected no word", tdata);
      end else chk("word", {15'd0, tlast, tdata}, {15'd0, exp_q.pop_front()});
      if (tlast) begin
        tlasts++;
        counting = 1;
        gap_cnt = 0;
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, tl;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_tvalid", {31'd0, tvalid}, 0);
    chk("rst_tlast", {31'd0, tlast}, 0);
    chk("rst_tdata", {16'd0, tdata}, 0);
    chk("rst_readdata", {24'd0, readdata}, 0);
    rd_chk("rst_len", 14, 0);
    rd_chk("rst_status", 19, 0);
    rd_chk("rst_sent", 20, 0);
    rd_chk("rst_csum", 21, 0);
    setup(DST, SRC, 16'h0800, 16'h0010, 4, 0, 1);
    foreach (golden[i]) exp_q.push_back({i == 13, golden[i]});
    wr(19, 1);
    wait_done("single_done");
    rd_chk("single_csum0", 21, 8'h46);
    rd_chk("single_csum1", 22, 8'h00);
    rd_chk("single_csum2", 23, 8'h00);
    rd_chk("single_csum3", 24, 8'h00);
    rd_chk("single_sent", 20, 1);
    rd_chk("single_busy", 19, 0);
    wr(25, 0);
    stalls = 0;
    rnd = 1;
    push_frame(DST, SRC, 16'h0800, 16'h0010, 4);
    wr(19, 1);
    wait_done("bp_done");
    rnd = 0;
    rd_chk("bp_csum0", 21, 8'h46);
    rd_chk("bp_sent", 20, 2);
`ifdef FRAME_TX_STALL_COUNT_EN
    rd_chk("bp_stall_lo", 25, 8'(stalls));
    rd_chk("bp_stall_hi", 26, 8'(stalls >> 8));
`endif
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    setup(DST, SRC, 16'h88B5, 16'h0100, 2, 5, 3);
    repeat (3) push_frame(DST, SRC, 16'h88B5, 16'h0100, 2);
    counting = 0;
    gap_q.delete();
    wr(19, 1);
    wait_done("burst_done");
    chk("burst_gap_count", gap_q.size(), 2);
    chk("burst_gap0", gap_q.size() > 0 ? gap_q[0] : 99, 5);
    chk("burst_gap1", gap_q.size() > 1 ? gap_q[1] : 99, 5);
    rd_chk("burst_sent", 20, 3);
    wr(15, 0);
    wr(18, 2);
    repeat (2) push_frame(DST, SRC, 16'h88B5, 16'h0100, 2);
    counting = 0;
    gap_q.delete();
    wr(19, 1);
    wait_done("b2b_done");
    chk("b2b_gap", gap_q.size() == 1 ? gap_q[0] : 99, 0);
    rd_chk("b2b_sent", 20, 5);
    wr(16, 8'hFE); wr(17, 8'hFF); wr(14, 4); wr(18, 1);
    push_frame(DST, SRC, 16'h88B5, 16'hFFFE, 4);
    wr(19, 1);
    wait_done("wrap_done");
    rd_chk("wrap_csum0", 21, 8'hFE);
    rd_chk("wrap_csum1", 22, 8'hFF);
    rd_chk("wrap_csum2", 23, 8'h01);
    rd_chk("wrap_csum3", 24, 8'h00);
    wr(14, 0);
    push_frame(DST, SRC, 16'h88B5, 16'hFFFE, 0);
    wr(19, 1);
    wait_done("len0_done");
    rd_chk("len0_csum2", 23, 8'h00);
    rd_chk("len0_csum0", 21, 8'hFE);
    rd_chk("len0_sent", 20, 7);
    setup(DST, SRC, 16'h0800, 16'h0000, 8, 0, 1);
    push_frame(DST, SRC, 16'h0800, 16'h0000, 8);
    tl = tlasts;
    wr(19, 1);
    n = 0;
    while (exp_q.size() > 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach_pay", {31'd0, n < 100}, 1);
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_tvalid", {31'd0, tvalid}, 0);
    chk("midrst_tlast", {31'd0, tlast}, 0);
    chk("midrst_no_tlast", tlasts, tl);
    rd_chk("midrst_busy", 19, 0);
    rd_chk("midrst_dst0", 0, 0);
    rd_chk("midrst_len", 14, 0);
    rd_chk("midrst_count", 18, 0);
    rd_chk("midrst_sent", 20, 0);
    rd_chk("midrst_csum", 21, 0);
    setup(DST, SRC, 16'h0800, 16'h0010, 4, 0, 1);
    push_frame(DST, SRC, 16'h0800, 16'h0010, 4);
    wr(19, 1);
    wait_done("clean_done");
    rd_chk("clean_csum0", 21, 8'h46);
    rd_chk("clean_sent", 20, 1);
    push_frame(DST, SRC, 16'h0800, 16'h0010, 4);
    wr(19, 1);
    wr(0, 8'hAA);
    wr(19, 1);
    wait_done("midwr_done");
    rd_chk("midwr_sent", 20, 2);
    rd_chk("midwr_busy", 19, 0);
    push_frame(DST2, SRC, 16'h0800, 16'h0010, 4);
    wr(19, 1);
    wait_done("newmac_done");
    rd_chk("newmac_sent", 20, 3);
    rd_chk("newmac_dst0", 0, 8'hAA);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
